// File: rtl/wgt_sched_pkg.sv
// Shared types and helpers for the weight-load scheduler: one-hot state
// encoding, kernel-size validation and kernel-area lookup.
package wgt_sched_pkg;

  localparam int SET_W_DEF  = 4;
  localparam int GRP_W_DEF  = 6;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_CHECK   = 7'b0000010,
    ST_WAITBUF = 7'b0000100,
    ST_ISSUE   = 7'b0001000,
    ST_RUN     = 7'b0010000,
    ST_ADV     = 7'b0100000,
    ST_FIN     = 7'b1000000
  } state_t;

  function automatic logic ksize_valid(input logic [2:0] ksize);
    return (ksize == 3'd1) || (ksize == 3'd3) || (ksize == 3'd5);
  endfunction

  // Words per channel group in a kernel bank: ksize squared.
  function automatic logic [4:0] ksq_lookup(input logic [2:0] ksize);
    logic [4:0] ksq;
    case (ksize)
      3'd3:    ksq = 5'd9;
      3'd5:    ksq = 5'd25;
      default: ksq = 5'd1;
    endcase
    return ksq;
  endfunction

endpackage

// File: rtl/wgt_load_sched_if.sv
// Layer-configuration handshake between the layer controller (master) and
// the weight-load scheduler (slave).
interface wgt_load_sched_if import wgt_sched_pkg::*; #(
  parameter int SET_W = SET_W_DEF,
  parameter int GRP_W = GRP_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_kernel_size;
  logic [SET_W-1:0] cfg_num_sets;
  logic [GRP_W-1:0] cfg_num_grps;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_kernel_size, cfg_num_sets, cfg_num_grps,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_kernel_size, cfg_num_sets, cfg_num_grps,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/wgt_pingpong_tracker.sv
// Ping-pong weight buffer bookkeeping: which buffer is being written and
// which buffers hold a loaded tile not yet released by the PE array.
module wgt_pingpong_tracker (
  input  logic       clock,
  input  logic       rst,
  input  logic       set_full,
  input  logic       toggle,
  input  logic [1:0] rel,
  output logic       sel,
  output logic [1:0] full,
  output logic       free
);

  logic [1:0] set_mask;

  assign set_mask = set_full ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign free     = ~full[sel];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; a blocking write here would leak into later reads.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sel  <= 1'b0;
      full <= 2'b00;
    end else begin
      // A load completing on the same edge as a release of that buffer wins.
      full <= set_mask | (full & ~rel);
      if (toggle) sel <= ~sel;
    end
  end

endmodule

// File: rtl/wgt_load_sched.sv
// Weight-load scheduler: walks one layer's (kernel set x channel group) tiles,
// triggers img2col_weight per tile and gates issue on a free ping-pong buffer.
module wgt_load_sched import wgt_sched_pkg::*; #(
  parameter int SET_W  = SET_W_DEF,
  parameter int GRP_W  = GRP_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  wgt_load_sched_if.slave   cfg,
  output logic              i2c_wgt_start,
  output logic [2:0]        i2c_kernel_size,
  input  logic              i2c_ready,
  output logic [SET_W-1:0]  bank_sel,
  output logic [ADDR_W-1:0] grp_base,
  output logic              wbuf_sel,
  output logic [1:0]        wbuf_full,
  input  logic [1:0]        wbuf_release,
  output logic              tile_last,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [2:0]       ksize_q;
  logic [4:0]       ksq_q;
  logic [SET_W-1:0] sets_q;
  logic [SET_W-1:0] set_idx;
  logic [GRP_W-1:0] grps_q;
  logic [GRP_W-1:0] grp_idx;
  logic             cfg_err_q;
  logic             done_q;
  logic             buf_free;
  logic             buf_set;
  logic             buf_toggle;

  // Start is exactly the ISSUE state flop, so it drops on the edge that sees
  // the engine go busy and clears asynchronously with rst.
  assign i2c_wgt_start   = (state == ST_ISSUE);
  assign cfg.cfg_ready   = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign cfg.cfg_err     = cfg_err_q;
  assign done            = done_q;
  assign i2c_kernel_size = ksize_q;
  assign bank_sel        = set_idx;

  assign tile_last = (set_idx == sets_q - SET_W'(1)) &&
                     (grp_idx == grps_q - GRP_W'(1));

  assign buf_set    = (state == ST_RUN) && i2c_ready;
  assign buf_toggle = (state == ST_ADV);

  wgt_pingpong_tracker u_tracker (
    .clock    (clock),
    .rst      (rst),
    .set_full (buf_set),
    .toggle   (buf_toggle),
    .rel      (wbuf_release),
    .sel      (wbuf_sel),
    .full     (wbuf_full),
    .free     (buf_free)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ksize_q   <= '0;
      ksq_q     <= '0;
      sets_q    <= '0;
      grps_q    <= '0;
      set_idx   <= '0;
      grp_idx   <= '0;
      grp_base  <= '0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            ksize_q  <= cfg.cfg_kernel_size;
            sets_q   <= cfg.cfg_num_sets;
            grps_q   <= cfg.cfg_num_grps;
            set_idx  <= '0;
            grp_idx  <= '0;
            grp_base <= '0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!ksize_valid(ksize_q) || (sets_q == '0) || (grps_q == '0)) begin
            cfg_err_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ksq_q <= ksq_lookup(ksize_q);
            state <= ST_WAITBUF;
          end
        end
        ST_WAITBUF: if (buf_free) state <= ST_ISSUE;
        ST_ISSUE:   if (!i2c_ready) state <= ST_RUN;
        ST_RUN:     if (i2c_ready) state <= ST_ADV;
        ST_ADV: begin
          // Base address accumulates ksq per group instead of multiplying.
          if (grp_idx == grps_q - GRP_W'(1)) begin
            grp_idx  <= '0;
            grp_base <= '0;
            set_idx  <= set_idx + SET_W'(1);
          end else begin
            grp_idx  <= grp_idx + GRP_W'(1);
            grp_base <= grp_base + ADDR_W'(ksq_q);
          end
          if (tile_last) begin
            done_q <= 1'b1;
            state  <= ST_FIN;
          end else begin
            state  <= ST_WAITBUF;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_load_sched.sv
// Self-checking bench for wgt_load_sched with a behavioural img2col_weight engine.
module tb_wgt_load_sched;

  localparam int ENG_LAT = 3;

  logic        clock;
  logic        rst;
  logic        i2c_wgt_start;
  logic [2:0]  i2c_kernel_size;
  logic        i2c_ready;
  logic [3:0]  bank_sel;
  logic [10:0] grp_base;
  logic        wbuf_sel;
  logic [1:0]  wbuf_full;
  logic [1:0]  wbuf_release;
  logic        tile_last;
  logic        busy;
  logic        done;

  logic        auto_rel;
  logic [1:0]  man_rel;
  int          eng_cnt;
  int          eng_trig;
  int          total;
  int          bad;

  wgt_load_sched_if #(.SET_W(4), .GRP_W(6)) cfg_bus ();

  wgt_load_sched #(.SET_W(4), .GRP_W(6), .ADDR_W(11)) dut (
    .clock           (clock),
    .rst             (rst),
    .cfg             (cfg_bus),
    .i2c_wgt_start   (i2c_wgt_start),
    .i2c_kernel_size (i2c_kernel_size),
    .i2c_ready       (i2c_ready),
    .bank_sel        (bank_sel),
    .grp_base        (grp_base),
    .wbuf_sel        (wbuf_sel),
    .wbuf_full       (wbuf_full),
    .wbuf_release    (wbuf_release),
    .tile_last       (tile_last),
    .busy            (busy),
    .done            (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // PE array model: either frees every loaded buffer at once or follows man_rel.
  assign wbuf_release = auto_rel ? wbuf_full : man_rel;

  // img2col_weight model: triggers on start while idle, busy for ENG_LAT+1 cycles.
  initial eng_trig = 0;
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      i2c_ready <= 1'b1;
      eng_cnt   <= 0;
    end else if (i2c_ready) begin
      if (i2c_wgt_start) begin
        i2c_ready <= 1'b0;
        eng_cnt   <= ENG_LAT;
        eng_trig  <= eng_trig + 1;
      end
    end else if (eng_cnt == 0) begin
      i2c_ready <= 1'b1;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  typedef struct {
    logic [2:0] ksize;
    logic [3:0] sets;
    logic [5:0] grps;
    int         first;
    int         cnt;
  } layer_t;

  typedef struct {
    logic [3:0]  bank;
    logic [10:0] base;
    logic        sel;
    logic        last;
  } tile_t;

  typedef struct {
    logic [2:0] ksize;
    logic [3:0] sets;
    logic [5:0] grps;
  } bad_cfg_t;

  layer_t   layers[4];
  tile_t    tiles[15];
  bad_cfg_t bad_cfgs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cfg_ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
    check({tag, "_cfg_err"},   32'(cfg_bus.cfg_err),   32'd0);
    check({tag, "_start"},     32'(i2c_wgt_start),     32'd0);
    check({tag, "_ksize"},     32'(i2c_kernel_size),   32'd0);
    check({tag, "_bank_sel"},  32'(bank_sel),          32'd0);
    check({tag, "_grp_base"},  32'(grp_base),          32'd0);
    check({tag, "_wbuf_sel"},  32'(wbuf_sel),          32'd0);
    check({tag, "_wbuf_full"}, 32'(wbuf_full),         32'd0);
    check({tag, "_tile_last"}, 32'(tile_last),         32'd0);
    check({tag, "_busy"},      32'(busy),              32'd0);
    check({tag, "_done"},      32'(done),              32'd0);
  endtask

  task automatic send_cfg(input logic [2:0] k, input logic [3:0] s, input logic [5:0] g);
    @(negedge clock);
    cfg_bus.cfg_valid       = 1'b1;
    cfg_bus.cfg_kernel_size = k;
    cfg_bus.cfg_num_sets    = s;
    cfg_bus.cfg_num_grps    = g;
    @(negedge clock);
    // Scramble the inputs: the layer must run from the latched copy.
    cfg_bus.cfg_valid       = 1'b0;
    cfg_bus.cfg_kernel_size = 3'd4;
    cfg_bus.cfg_num_sets    = 4'd0;
    cfg_bus.cfg_num_grps    = 6'd0;
  endtask

  task automatic wait_start(input logic val);
    for (int i = 0; i < 200; i++) begin
      if (i2c_wgt_start == val) break;
      @(negedge clock);
    end
    check("wait_start", 32'(i2c_wgt_start), 32'(val));
  endtask

  task automatic wait_ready(input logic val);
    for (int i = 0; i < 200; i++) begin
      if (i2c_ready == val) break;
      @(negedge clock);
    end
    check("wait_ready", 32'(i2c_ready), 32'(val));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(negedge clock);
    end
    check("wait_done", 32'(done), 32'd1);
  endtask

  task automatic run_layer(input int li);
    int   seen;
    int   idx;
    int   trig0;
    logic prev;
    logic got_done;
    seen     = 0;
    prev     = 1'b0;
    got_done = 1'b0;
    trig0    = eng_trig;
    send_cfg(layers[li].ksize, layers[li].sets, layers[li].grps);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (i2c_wgt_start && !prev) begin
        if (seen < layers[li].cnt) begin
          idx = layers[li].first + seen;
          check($sformatf("L%0d_T%0d_bank", li, seen), 32'(bank_sel),  32'(tiles[idx].bank));
          check($sformatf("L%0d_T%0d_base", li, seen), 32'(grp_base),  32'(tiles[idx].base));
          check($sformatf("L%0d_T%0d_sel",  li, seen), 32'(wbuf_sel),  32'(tiles[idx].sel));
          check($sformatf("L%0d_T%0d_last", li, seen), 32'(tile_last), 32'(tiles[idx].last));
          check($sformatf("L%0d_T%0d_ksz",  li, seen), 32'(i2c_kernel_size), 32'(layers[li].ksize));
        end
        seen++;
      end
      prev = i2c_wgt_start;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check($sformatf("L%0d_done_seen", li),   32'(got_done), 32'd1);
    check($sformatf("L%0d_start_count", li), 32'(seen), 32'(layers[li].cnt));
    check($sformatf("L%0d_engine_trig", li), 32'(eng_trig - trig0), 32'(layers[li].cnt));
    @(negedge clock);
    check($sformatf("L%0d_done_1cyc", li),  32'(done), 32'd0);
    check($sformatf("L%0d_ready_after", li), 32'(cfg_bus.cfg_ready), 32'd1);
    check($sformatf("L%0d_busy_after", li),  32'(busy), 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    auto_rel = 1'b0;
    man_rel  = 2'b00;
    cfg_bus.cfg_valid       = 1'b0;
    cfg_bus.cfg_kernel_size = 3'd0;
    cfg_bus.cfg_num_sets    = 4'd0;
    cfg_bus.cfg_num_grps    = 6'd0;

    layers[0] = '{3'd3, 4'd1, 6'd2, 0,  2};
    layers[1] = '{3'd1, 4'd3, 6'd1, 2,  3};
    layers[2] = '{3'd5, 4'd2, 6'd2, 5,  4};
    layers[3] = '{3'd3, 4'd2, 6'd3, 9,  6};

    tiles[0]  = '{4'd0, 11'd0,  1'b0, 1'b0};
    tiles[1]  = '{4'd0, 11'd9,  1'b1, 1'b1};
    tiles[2]  = '{4'd0, 11'd0,  1'b0, 1'b0};
    tiles[3]  = '{4'd1, 11'd0,  1'b1, 1'b0};
    tiles[4]  = '{4'd2, 11'd0,  1'b0, 1'b1};
    tiles[5]  = '{4'd0, 11'd0,  1'b0, 1'b0};
    tiles[6]  = '{4'd0, 11'd25, 1'b1, 1'b0};
    tiles[7]  = '{4'd1, 11'd0,  1'b0, 1'b0};
    tiles[8]  = '{4'd1, 11'd25, 1'b1, 1'b1};
    tiles[9]  = '{4'd0, 11'd0,  1'b0, 1'b0};
    tiles[10] = '{4'd0, 11'd9,  1'b1, 1'b0};
    tiles[11] = '{4'd0, 11'd18, 1'b0, 1'b0};
    tiles[12] = '{4'd1, 11'd0,  1'b1, 1'b0};
    tiles[13] = '{4'd1, 11'd9,  1'b0, 1'b0};
    tiles[14] = '{4'd1, 11'd18, 1'b1, 1'b1};

    bad_cfgs[0] = '{3'd4, 4'd1, 6'd1};
    bad_cfgs[1] = '{3'd3, 4'd0, 6'd2};
    bad_cfgs[2] = '{3'd5, 4'd2, 6'd0};
    bad_cfgs[3] = '{3'd0, 4'd1, 6'd1};
    bad_cfgs[4] = '{3'd7, 4'd1, 6'd1};
    bad_cfgs[5] = '{3'd2, 4'd1, 6'd1};

    // Full layers with buffers freed as soon as they fill.
    auto_rel = 1'b1;
    for (int li = 0; li < 4; li++) begin
      apply_reset();
      check_reset_vals($sformatf("rst%0d", li));
      run_layer(li);
    end

    // Rejected configurations.
    apply_reset();
    for (int e = 0; e < 6; e++) begin
      send_cfg(bad_cfgs[e].ksize, bad_cfgs[e].sets, bad_cfgs[e].grps);
      check($sformatf("E%0d_busy_check", e),  32'(busy), 32'd1);
      check($sformatf("E%0d_ready_check", e), 32'(cfg_bus.cfg_ready), 32'd0);
      @(negedge clock);
      check($sformatf("E%0d_err_pulse", e),   32'(cfg_bus.cfg_err), 32'd1);
      check($sformatf("E%0d_ready_back", e),  32'(cfg_bus.cfg_ready), 32'd1);
      check($sformatf("E%0d_no_start", e),    32'(i2c_wgt_start), 32'd0);
      @(negedge clock);
      check($sformatf("E%0d_err_1cyc", e),    32'(cfg_bus.cfg_err), 32'd0);
      check($sformatf("E%0d_no_start2", e),   32'(i2c_wgt_start), 32'd0);
      check($sformatf("E%0d_idle", e),        32'(busy), 32'd0);
    end

    // Both buffers fill without release; releasing buf0 lets tile 3 issue.
    auto_rel = 1'b0;
    apply_reset();
    send_cfg(3'd5, 4'd2, 6'd3);
    wait_start(1'b1);
    wait_start(1'b0);
    wait_start(1'b1);
    wait_start(1'b0);
    repeat (20) @(negedge clock);
    check("stall_full",  32'(wbuf_full), 32'd3);
    check("stall_start", 32'(i2c_wgt_start), 32'd0);
    check("stall_busy",  32'(busy), 32'd1);
    check("stall_bank",  32'(bank_sel), 32'd0);
    check("stall_base",  32'(grp_base), 32'd50);
    check("stall_sel",   32'(wbuf_sel), 32'd0);
    man_rel = 2'b01;
    @(negedge clock);
    man_rel = 2'b00;
    check("rel0_full", 32'(wbuf_full), 32'd2);
    wait_start(1'b1);
    check("t3_bank", 32'(bank_sel), 32'd0);
    check("t3_base", 32'(grp_base), 32'd50);
    check("t3_sel",  32'(wbuf_sel), 32'd0);
    check("t3_last", 32'(tile_last), 32'd0);

    // Release racing the fill edge: same buffer keeps full, other buffer clears.
    apply_reset();
    send_cfg(3'd1, 4'd1, 6'd2);
    wait_start(1'b1);
    wait_start(1'b0);
    wait_ready(1'b1);
    man_rel = 2'b01;
    @(negedge clock);
    man_rel = 2'b00;
    check("set_wins_full", 32'(wbuf_full), 32'd1);
    wait_start(1'b1);
    check("t2_sel",  32'(wbuf_sel), 32'd1);
    check("t2_last", 32'(tile_last), 32'd1);
    wait_start(1'b0);
    wait_ready(1'b1);
    man_rel = 2'b01;
    @(negedge clock);
    man_rel = 2'b00;
    check("set_rel_other_full", 32'(wbuf_full), 32'd2);
    wait_done();
    man_rel = 2'b01;
    @(negedge clock);
    man_rel = 2'b00;
    check("rel_nonfull_ignored", 32'(wbuf_full), 32'd2);
    man_rel = 2'b10;
    @(negedge clock);
    man_rel = 2'b00;
    check("rel_buf1", 32'(wbuf_full), 32'd0);

    // Asynchronous reset during RUN of tile 2, then a fresh layer.
    auto_rel = 1'b1;
    apply_reset();
    send_cfg(3'd3, 4'd2, 6'd2);
    wait_start(1'b1);
    wait_start(1'b0);
    wait_start(1'b1);
    wait_start(1'b0);
    check("run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    rst = 1'b0;
    run_layer(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
